// File: rtl/spmm_row_scheduler_if.sv
// Handshake and broadcast bundle between the H-row scheduler and its upstream streams / PE bank.
// Signal names keep the scheduler-side direction suffixes so they match the block's port list.
interface spmm_row_scheduler_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_FEATURE_IN = 1433,
    parameter int MAX_NODES      = 168,
    parameter int TOTAL_NODES    = 13264,
    parameter int NUM_PE         = 16
);
    localparam int COL_IDX_WIDTH  = $clog2(NUM_FEATURE_IN);
    localparam int ROW_LEN_WIDTH  = $clog2(NUM_FEATURE_IN);
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int ROW_CNT_W      = $clog2(TOTAL_NODES + 1);

    logic                      start_i;
    logic                      done_o;
    logic                      ni_vld_i;
    logic                      ni_rdy_o;
    logic [ROW_LEN_WIDTH-1:0]  row_len_i;
    logic [NUM_NODE_WIDTH-1:0] num_node_i;
    logic                      src_flag_i;
    logic                      h_vld_i;
    logic                      h_rdy_o;
    logic [COL_IDX_WIDTH-1:0]  col_idx_i;
    logic [DATA_WIDTH-1:0]     val_i;
    logic [NUM_PE-1:0]         pe_rdy_i;
    logic [NUM_PE-1:0]         pe_vld_o;
    logic [NUM_PE-1:0]         spmm_vld_o;
    logic [COL_IDX_WIDTH-1:0]  col_idx_o;
    logic [DATA_WIDTH-1:0]     val_o;
    logic [ROW_LEN_WIDTH-1:0]  row_len_o;
    logic [NUM_NODE_WIDTH-1:0] num_node_o;
    logic                      src_flag_o;
    logic                      empty_row_o;
    logic [ROW_CNT_W-1:0]      rows_issued_o;
    logic [NUM_PE-1:0]         pe_busy_o;

    modport master (
        output start_i, ni_vld_i, row_len_i, num_node_i, src_flag_i,
               h_vld_i, col_idx_i, val_i, pe_rdy_i,
        input  done_o, ni_rdy_o, h_rdy_o, pe_vld_o, spmm_vld_o, col_idx_o, val_o,
               row_len_o, num_node_o, src_flag_o, empty_row_o, rows_issued_o, pe_busy_o
    );

    modport slave (
        input  start_i, ni_vld_i, row_len_i, num_node_i, src_flag_i,
               h_vld_i, col_idx_i, val_i, pe_rdy_i,
        output done_o, ni_rdy_o, h_rdy_o, pe_vld_o, spmm_vld_o, col_idx_o, val_o,
               row_len_o, num_node_o, src_flag_o, empty_row_o, rows_issued_o, pe_busy_o
    );
endinterface

// File: rtl/spmm_row_scheduler.sv
// Front-end scheduler for the sparse x dense PE bank: hands each CSR row of H to a free PE
// (round-robin), issues its header, streams its nonzeros, and reports done once all PEs idle.
module spmm_row_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_FEATURE_IN = 1433,
    parameter int MAX_NODES      = 168,
    parameter int TOTAL_NODES    = 13264,
    parameter int NUM_PE         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    spmm_row_scheduler_if.slave bus
);
    localparam int COL_IDX_WIDTH  = $clog2(NUM_FEATURE_IN);
    localparam int ROW_LEN_WIDTH  = $clog2(NUM_FEATURE_IN);
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int ROW_CNT_W      = $clog2(TOTAL_NODES + 1);
    localparam int PE_IDX_W       = $clog2(NUM_PE);

    typedef enum logic [2:0] {IDLE, FETCH, SELECT, ISSUE, STREAM, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [PE_IDX_W-1:0]       ptr, sel, pick, idx;
    logic                      pick_found;
    logic [ROW_LEN_WIDTH-1:0]  beat_cnt, row_len;
    logic [NUM_NODE_WIDTH-1:0] num_node;
    logic                      src_flag, empty_row, done, ni_rdy, h_rdy;
    logic [COL_IDX_WIDTH-1:0]  col_idx;
    logic [DATA_WIDTH-1:0]     val;
    logic [ROW_CNT_W-1:0]      rows_issued;
    logic [NUM_PE-1:0]         busy, pe_vld, spmm_vld, set_mask;
    logic                      ni_hs, h_hs, last_beat, last_row_fetch, last_row_stream;

    function automatic logic [NUM_PE-1:0] pe_onehot(input logic [PE_IDX_W-1:0] k);
        return {{(NUM_PE-1){1'b0}}, 1'b1} << k;
    endfunction

    assign ni_hs           = bus.ni_vld_i && ni_rdy;
    assign h_hs            = bus.h_vld_i && h_rdy;
    assign last_beat       = h_hs && (beat_cnt == row_len - ROW_LEN_WIDTH'(1));
    assign last_row_fetch  = (rows_issued + ROW_CNT_W'(1)) == ROW_CNT_W'(TOTAL_NODES);
    assign last_row_stream = rows_issued == ROW_CNT_W'(TOTAL_NODES);
    assign set_mask        = (state == SELECT && pick_found) ? pe_onehot(pick) : '0;

    // Round-robin: first free PE after the most recently issued one.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int i = 1; i <= NUM_PE; i++) begin
            idx = PE_IDX_W'((int'(ptr) + i) % NUM_PE);
            if (!pick_found && !busy[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (bus.start_i) state_n = FETCH;
            FETCH: begin
                if (ni_hs) begin
                    if (bus.row_len_i == '0) state_n = last_row_fetch ? DRAIN : FETCH;
                    else                     state_n = SELECT;
                end
            end
            SELECT:  if (pick_found) state_n = ISSUE;
            ISSUE:   state_n = STREAM;
            STREAM:  if (last_beat) state_n = last_row_stream ? DRAIN : FETCH;
            DRAIN:   if (busy == '0) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Ready flags are registered from the next state so they line up with the state they serve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= PE_IDX_W'(NUM_PE - 1);
            sel         <= '0;
            beat_cnt    <= '0;
            row_len     <= '0;
            num_node    <= '0;
            src_flag    <= 1'b0;
            empty_row   <= 1'b0;
            done        <= 1'b0;
            ni_rdy      <= 1'b0;
            h_rdy       <= 1'b0;
            col_idx     <= '0;
            val         <= '0;
            rows_issued <= '0;
            busy        <= '0;
            pe_vld      <= '0;
            spmm_vld    <= '0;
        end else begin
            pe_vld    <= '0;
            spmm_vld  <= '0;
            empty_row <= 1'b0;
            ni_rdy    <= (state_n == FETCH);
            h_rdy     <= (state_n == STREAM);
            busy      <= (busy & ~bus.pe_rdy_i) | set_mask;
            case (state)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        rows_issued <= '0;
                        done        <= 1'b0;
                    end
                end
                FETCH: begin
                    if (ni_hs) begin
                        row_len     <= bus.row_len_i;
                        num_node    <= bus.num_node_i;
                        src_flag    <= bus.src_flag_i;
                        rows_issued <= rows_issued + ROW_CNT_W'(1);
                        empty_row   <= (bus.row_len_i == '0);
                    end
                end
                SELECT: begin
                    if (pick_found) begin
                        sel      <= pick;
                        ptr      <= pick;
                        pe_vld   <= pe_onehot(pick);
                        beat_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (h_hs) begin
                        spmm_vld <= pe_onehot(sel);
                        col_idx  <= bus.col_idx_i;
                        val      <= bus.val_i;
                        beat_cnt <= beat_cnt + ROW_LEN_WIDTH'(1);
                    end
                end
                DRAIN: if (busy == '0) done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.done_o        = done;
    assign bus.ni_rdy_o      = ni_rdy;
    assign bus.h_rdy_o       = h_rdy;
    assign bus.pe_vld_o      = pe_vld;
    assign bus.spmm_vld_o    = spmm_vld;
    assign bus.col_idx_o     = col_idx;
    assign bus.val_o         = val;
    assign bus.row_len_o     = row_len;
    assign bus.num_node_o    = num_node;
    assign bus.src_flag_o    = src_flag;
    assign bus.empty_row_o   = empty_row;
    assign bus.rows_issued_o = rows_issued;
    assign bus.pe_busy_o     = busy;
endmodule
